// File: rtl/multiply_if.sv
// Start/done handshake bundle for the sequential shift-add multiplier.
interface multiply_if #(
  parameter int N = 4
);
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           start;
  logic [2*N-1:0] p;
  logic           done_multiply;
  logic           busy;

  modport master (
    output a, b, start,
    input  p, done_multiply, busy
  );

  modport slave (
    input  a, b, start,
    output p, done_multiply, busy
  );
endinterface

// File: rtl/multiply_block.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per clock.
// Product and a one-cycle done pulse appear N+1 edges after the start edge.
module multiply_block #(
  parameter int N = 4
) (
  input logic      clk,
  input logic      rst,
  multiply_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           start_d;
  logic           start_ev;
  logic [W-1:0]   mcand;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_nxt;
  logic [W-1:0]   p;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  count;
  logic           done;

  assign start_ev = bus.start & ~start_d;
  assign acc_nxt  = mplier[0] ? acc + mcand : acc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ev) state_nxt = RUN;
      RUN:     if (count == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      start_d <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      p       <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_d <= bus.start;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ev) begin
            mcand  <= {{N{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            count  <= CW'(N);
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
        end
        // publish the finished accumulator as the new product
        DONE: begin
          p    <= acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.p             = p;
  assign bus.done_multiply = done;
  assign bus.busy          = (state == RUN);
endmodule

// File: tb/tb_multiply_block.sv
// Bench for multiply_block: directed handshake cases, exhaustive sweep
// and random operations checked against plain a*b arithmetic.
module tb_multiply_block;
  localparam int N   = 4;
  localparam int LAT = N + 1;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errs    = 0;

  multiply_if #(.N(N)) bus();

  multiply_block #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and watch 12 edges from the start edge on.
  task automatic op(input int av, input int bv,
                    input int hold, input bit glitch,
                    input string tag);
    int ndone, lat, bcnt, pmoves, exp;
    logic [2*N-1:0] pv, pold;
    exp    = (av * bv) % (1 << (2 * N));
    ndone  = 0;
    lat    = -1;
    bcnt   = 0;
    pmoves = 0;
    pv     = '0;
    pold   = bus.p;
    bus.a     = N'(av);
    bus.b     = N'(bv);
    bus.start = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == hold) bus.start = 1'b0;
      if (glitch && e == 2) begin
        bus.start = 1'b1;
        bus.a     = N'(1);
        bus.b     = N'(1);
      end
      if (glitch && e == 3) bus.start = 1'b0;
      if (bus.done_multiply === 1'b1) begin
        ndone++;
        if (lat < 0) lat = e - 1;
        pv = bus.p;
      end
      if (bus.busy === 1'b1) begin
        bcnt++;
        if (e > LAT - 1) pmoves++;
      end
      if (e <= LAT - 1 && bus.p !== pold) pmoves++;
    end
    check({tag, "_pulses"}, ndone, 1);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_p_at_done"}, pv, exp);
    check({tag, "_busy_cycles"}, bcnt, N);
    check({tag, "_p_stable_run"}, pmoves, 0);
    check({tag, "_p_hold"}, bus.p, exp);
  endtask

  initial begin
    int ra, rb, rh;
    bit seen;
    rst       = 1'b1;
    bus.a     = '0;
    bus.b     = '0;
    bus.start = 1'b0;
    tick();
    tick();
    check("reset_p", bus.p, 0);
    check("reset_done", bus.done_multiply, 0);
    check("reset_busy", bus.busy, 0);
    rst = 1'b0;
    tick();

    op(4, 2, 1, 1'b0, "t1_4x2");
    op(0, 2, 5, 1'b0, "t2_held");
    op(9, 2, 1, 1'b0, "t3_9x2");
    op(3, 6, 1, 1'b0, "t3_3x6");
    op(15, 15, 1, 1'b0, "t3_15x15");
    repeat (4) tick();
    check("t3_idle_hold", bus.p, 225);

    op(7, 5, 1, 1'b0, "t4_pre");
    op(7, 5, 1, 1'b1, "t4_glitch");

    bus.a     = N'(6);
    bus.b     = N'(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_abort_p", bus.p, 0);
    check("t5_abort_busy", bus.busy, 0);
    seen = 1'b0;
    for (int e = 0; e < 8; e++) begin
      if (bus.done_multiply === 1'b1) seen = 1'b1;
      tick();
    end
    check("t5_no_pulse", seen, 0);

    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    check("rst_beats_start", bus.busy, 0);
    tick();
    op(2, 3, 1, 1'b0, "t5_after");

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op(i, j, 1, 1'b0, "sweep");

    for (int k = 0; k < 40; k++) begin
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      rh = int'($urandom_range(5, 1));
      op(ra, rb, rh, 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
